// File: rtl/riscv_pkg.sv
// Shared core-wide constants: data width, register address width, x0 alias.
// Latency: none (declarations only).
// Backpressure: not applicable.
package riscv_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

   // Writes to x0 are architecturally discarded everywhere in the core.
   function automatic logic is_x0(input reg_addr_t a);
      return a == REG_ZERO;
   endfunction
endpackage

// File: rtl/wb_result_fifo.sv
// Small circular buffer of {rd,data} multi-cycle results with per-entry taps for the scoreboard.
// Latency: a pushed entry is visible at the head on the following cycle; pop is same-cycle.
// Backpressure: push is ignored while full, pop is ignored while empty; the owner gates on full/empty.
module wb_result_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int DW    = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  reg_addr_t              push_rd,
   input  logic [DW-1:0]          push_data,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output reg_addr_t              head_rd,
   output logic [DW-1:0]          head_data,
   output reg_addr_t [DEPTH-1:0]  ent_rd,
   output logic [DEPTH-1:0]       ent_vld
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]               count_q, count_d;
   reg_addr_t [DEPTH-1:0]       rd_mem_q, rd_mem_d;
   logic [DEPTH-1:0][DW-1:0]    data_mem_q, data_mem_d;
   logic                        do_push, do_pop;
   logic [PW-1:0]               off;

   // Occupancy flags, head taps and per-entry validity relative to the read pointer.
   always_comb begin
      full      = (count_q == CW'(DEPTH));
      empty     = (count_q == '0);
      head_rd   = rd_mem_q[rd_ptr_q];
      head_data = data_mem_q[rd_ptr_q];
      ent_rd    = rd_mem_q;
      ent_vld   = '0;
      off       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off        = PW'(i) - rd_ptr_q;
         ent_vld[i] = ({1'b0, off} < count_q);
      end
   end

   // Next-state for storage, pointers (power-of-two wrap) and count.
   always_comb begin
      do_push    = push && !full;
      do_pop     = pop && !empty;
      rd_mem_d   = rd_mem_q;
      data_mem_d = data_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (do_push) begin
         rd_mem_d[wr_ptr_q]   = push_rd;
         data_mem_d[wr_ptr_q] = push_data;
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   // State registers; reset discards any buffered results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_mem_q   <= '0;
         data_mem_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_mem_q   <= rd_mem_d;
         data_mem_q <= data_mem_d;
      end
   end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port: pipeline writeback wins, multi-cycle results queue and drain when idle.
// Latency: pipeline writes pass through combinationally; a multi-cycle result is written >= 1 cycle after acceptance.
// Backpressure: mc_ready drops when the queue is full; stall_req asks the hazard unit for a drain bubble.
module wb_port_arbiter #(
   parameter int XLEN       = 32,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              pipe_we,
   input  logic [riscv_pkg::REG_ADDR_W-1:0]  pipe_rd,
   input  logic [XLEN-1:0]                   pipe_data,
   input  logic                              mc_valid,
   input  logic [riscv_pkg::REG_ADDR_W-1:0]  mc_rd,
   input  logic [XLEN-1:0]                   mc_data,
   output logic                              mc_ready,
   output logic                              rf_we,
   output logic [riscv_pkg::REG_ADDR_W-1:0]  rf_addr,
   output logic [XLEN-1:0]                   rf_wdata,
   input  logic [riscv_pkg::REG_ADDR_W-1:0]  hz_rs1,
   input  logic [riscv_pkg::REG_ADDR_W-1:0]  hz_rs2,
   output logic                              hz_rs1_pend,
   output logic                              hz_rs2_pend,
   output logic                              stall_req
);
   import riscv_pkg::*;

   localparam int SCW = $clog2(STARVE_MAX + 1);
   localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

   logic                    pipe_act, mc_accept, push, pop;
   logic                    full, empty;
   reg_addr_t               head_rd;
   logic [XLEN-1:0]         head_data;
   reg_addr_t [DEPTH-1:0]   ent_rd;
   logic [DEPTH-1:0]        ent_vld;
   logic [SCW-1:0]          starve_q, starve_d;
   logic                    pipe_hits_fifo;

   wb_result_fifo #(.DEPTH(DEPTH), .DW(XLEN)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_rd   (mc_rd),
      .push_data (mc_data),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .head_rd   (head_rd),
      .head_data (head_data),
      .ent_rd    (ent_rd),
      .ent_vld   (ent_vld)
   );

   // Port mux: a live pipeline write owns the port, otherwise the queue head drains.
   always_comb begin
      pipe_act  = pipe_we && !is_x0(pipe_rd);
      mc_ready  = !full;
      mc_accept = mc_valid && !full;
      push      = mc_accept && !is_x0(mc_rd);
      pop       = !pipe_act && !empty;
      rf_we     = 1'b0;
      rf_addr   = REG_ZERO;
      rf_wdata  = '0;
      if (pipe_act) begin
         rf_we    = 1'b1;
         rf_addr  = pipe_rd;
         rf_wdata = pipe_data;
      end else if (!empty) begin
         rf_we    = 1'b1;
         rf_addr  = head_rd;
         rf_wdata = head_data;
      end
   end

   // Starvation counter: counts consecutive blocked cycles of a waiting head, saturating.
   always_comb begin
      starve_d = starve_q;
      if (empty || pop) begin
         starve_d = '0;
      end else if (pipe_act && starve_q != STARVE_LIM) begin
         starve_d = starve_q + SCW'(1);
      end
      stall_req = full || (starve_q == STARVE_LIM);
   end

   // Starvation counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

   // Scoreboard: a source is pending if a queued or just-accepted result targets it.
   always_comb begin
      hz_rs1_pend    = 1'b0;
      hz_rs2_pend    = 1'b0;
      pipe_hits_fifo = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i] && ent_rd[i] == hz_rs1)  hz_rs1_pend    = 1'b1;
         if (ent_vld[i] && ent_rd[i] == hz_rs2)  hz_rs2_pend    = 1'b1;
         if (ent_vld[i] && ent_rd[i] == pipe_rd) pipe_hits_fifo = pipe_act;
      end
      if (mc_accept && mc_rd == hz_rs1) hz_rs1_pend = 1'b1;
      if (mc_accept && mc_rd == hz_rs2) hz_rs2_pend = 1'b1;
      if (is_x0(hz_rs1)) hz_rs1_pend = 1'b0;
      if (is_x0(hz_rs2)) hz_rs2_pend = 1'b0;
   end

   // The hazard unit must never let W overwrite a register whose older multi-cycle result is still queued.
   a_no_waw_over_queue: assert property (@(posedge clk) disable iff (!rst_n) !pipe_hits_fifo);
endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
   localparam int XLEN       = 32;
   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic        clk;
   logic        rst_n;
   logic        pipe_we;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        mc_valid;
   logic [4:0]  mc_rd;
   logic [31:0] mc_data;
   logic        mc_ready;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_wdata;
   logic [4:0]  hz_rs1;
   logic [4:0]  hz_rs2;
   logic        hz_rs1_pend;
   logic        hz_rs2_pend;
   logic        stall_req;

   // Reference model state: queued results in arrival order and the blocked-head run length.
   ent_t mq[$];
   int   starve;
   bit   prev_stall;
   int   n_chk;
   int   n_fail;

   // Random multi-cycle producer state (holds its offer until accepted).
   bit          mc_pend;
   logic [4:0]  mc_pend_rd;
   logic [31:0] mc_pend_data;

   wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pipe_we     (pipe_we),
      .pipe_rd     (pipe_rd),
      .pipe_data   (pipe_data),
      .mc_valid    (mc_valid),
      .mc_rd       (mc_rd),
      .mc_data     (mc_data),
      .mc_ready    (mc_ready),
      .rf_we       (rf_we),
      .rf_addr     (rf_addr),
      .rf_wdata    (rf_wdata),
      .hz_rs1      (hz_rs1),
      .hz_rs2      (hz_rs2),
      .hz_rs1_pend (hz_rs1_pend),
      .hz_rs2_pend (hz_rs2_pend),
      .stall_req   (stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit queued(input logic [4:0] r);
      foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit exp_pend(input logic [4:0] r, input bit accepting, input logic [4:0] arrd);
      if (r == 5'd0) return 1'b0;
      if (accepting && arrd == r) return 1'b1;
      return queued(r);
   endfunction

   // One cycle: drive at negedge, compare against the model, then advance the model across the edge.
   task automatic step(input bit pwe, input logic [4:0] prd, input logic [31:0] pdat,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] mdat,
                       input logic [4:0] r1, input logic [4:0] r2, output bit acc);
      bit          pact, rdy, ewe, estall, had;
      logic [4:0]  eaddr;
      logic [31:0] edat;
      @(negedge clk);
      pipe_we = pwe; pipe_rd = prd; pipe_data = pdat;
      mc_valid = mv; mc_rd = mrd; mc_data = mdat;
      hz_rs1 = r1; hz_rs2 = r2;
      #1;
      pact   = pwe && (prd != 5'd0);
      rdy    = (mq.size() < DEPTH);
      had    = (mq.size() > 0);
      acc    = mv && rdy;
      estall = (mq.size() == DEPTH) || (starve == STARVE_MAX);
      if (pact) begin
         ewe = 1'b1; eaddr = prd; edat = pdat;
      end else if (had) begin
         ewe = 1'b1; eaddr = mq[0].rd; edat = mq[0].data;
      end else begin
         ewe = 1'b0; eaddr = 5'd0; edat = 32'd0;
      end
      check("rf_we",     64'(rf_we),       64'(ewe));
      check("rf_addr",   64'(rf_addr),     64'(eaddr));
      check("rf_wdata",  64'(rf_wdata),    64'(edat));
      check("mc_ready",  64'(mc_ready),    64'(rdy));
      check("stall_req", 64'(stall_req),   64'(estall));
      check("rs1_pend",  64'(hz_rs1_pend), 64'(exp_pend(r1, acc, mrd)));
      check("rs2_pend",  64'(hz_rs2_pend), 64'(exp_pend(r2, acc, mrd)));
      prev_stall = estall;
      if (!pact && had) void'(mq.pop_front());
      if (had && pact) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
      else             starve = 0;
      if (acc && mrd != 5'd0) mq.push_back('{rd: mrd, data: mdat});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rf_we"},     64'(rf_we),       64'd0);
      check({tag, "_rf_addr"},   64'(rf_addr),     64'd0);
      check({tag, "_rf_wdata"},  64'(rf_wdata),    64'd0);
      check({tag, "_mc_ready"},  64'(mc_ready),    64'd1);
      check({tag, "_stall_req"}, 64'(stall_req),   64'd0);
      check({tag, "_rs1_pend"},  64'(hz_rs1_pend), 64'd0);
      check({tag, "_rs2_pend"},  64'(hz_rs2_pend), 64'd0);
   endtask

   task automatic random_cycles(input int n);
      bit          acc, pwe;
      logic [4:0]  prd, r1, r2;
      for (int c = 0; c < n; c++) begin
         if (!mc_pend && ($urandom % 3 == 0)) begin
            mc_pend      = 1'b1;
            mc_pend_rd   = 5'($urandom % 32);
            mc_pend_data = $urandom;
         end
         pwe = prev_stall ? 1'b0 : ($urandom % 4 != 0);
         prd = 5'($urandom % 32);
         for (int t = 0; t < 8 && queued(prd); t++) prd = 5'($urandom % 32);
         if (queued(prd)) prd = 5'd0;
         r1 = (mq.size() > 0 && $urandom % 2 == 1) ? mq[0].rd : 5'($urandom % 32);
         r2 = (mq.size() > 0 && $urandom % 2 == 1) ? mq[mq.size()-1].rd
            : (mc_pend && $urandom % 2 == 1) ? mc_pend_rd : 5'($urandom % 32);
         step(pwe, prd, $urandom, mc_pend, mc_pend_rd, mc_pend_data, r1, r2, acc);
         if (acc) mc_pend = 1'b0;
      end
   endtask

   initial begin
      bit acc, done;
      n_chk = 0; n_fail = 0; starve = 0; prev_stall = 1'b0; mc_pend = 1'b0;
      mc_pend_rd = 5'd0; mc_pend_data = 32'd0;

      // Reset with an offer present: nothing may be accepted or written.
      rst_n = 1'b0;
      pipe_we = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
      mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'h1234_5678;
      hz_rs1 = 5'd5; hz_rs2 = 5'd9;
      #22;
      check_reset_outputs("reset");
      @(negedge clk);
      mc_valid = 1'b0;
      rst_n = 1'b1;

      // Idle drain.
      step(0, 5'd0, 32'd0, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, acc);
      step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0,         5'd5, 5'd0, acc);
      step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0,         5'd5, 5'd0, acc);

      // Contention: pipeline keeps the port, head starves until stall_req, then drains.
      step(1, 5'd3, 32'h0000_0003, 1, 5'd7, 32'h7777_0007, 5'd7, 5'd3, acc);
      for (int k = 0; k < 5; k++)
         step(1, 5'd3, 32'h3000 + k, 0, 5'd0, 32'd0, 5'd7, 5'd3, acc);
      step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd7, 5'd0, acc);
      step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd7, 5'd0, acc);

      // Full: two queued under constant pipe writes, third offer held until space opens.
      step(1, 5'd3, 32'h31, 1, 5'd8, 32'h8888_0008, 5'd8, 5'd9, acc);
      step(1, 5'd3, 32'h32, 1, 5'd9, 32'h9999_0009, 5'd8, 5'd9, acc);
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         step(k < 3, 5'd3, 32'h40 + k, 1, 5'd10, 32'hAAAA_000A, 5'd10, 5'd9, acc);
         done = acc;
      end
      check("full_third_accepted", 64'(done), 64'd1);
      for (int k = 0; k < 3; k++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd10, 5'd0, acc);

      // x0: rd=0 result is accepted but never written; rd=0 pipeline write leaves the port free.
      step(0, 5'd0, 32'd0, 1, 5'd0, 32'h0BAD_0000, 5'd0, 5'd0, acc);
      step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0,         5'd0, 5'd0, acc);
      step(1, 5'd3, 32'h50, 1, 5'd11, 32'hBBBB_000B, 5'd11, 5'd0, acc);
      step(1, 5'd0, 32'h51, 0, 5'd0, 32'd0,          5'd11, 5'd0, acc);
      step(0, 5'd0, 32'd0,  0, 5'd0, 32'd0,          5'd11, 5'd0, acc);

      // Scoreboard: rd=12 pending while blocked, clears after its write; rs2=x0 never pending.
      step(1, 5'd4, 32'h60, 1, 5'd12, 32'hCCCC_000C, 5'd12, 5'd0, acc);
      for (int k = 0; k < 3; k++) step(1, 5'd4, 32'h61 + k, 0, 5'd0, 32'd0, 5'd12, 5'd0, acc);
      for (int k = 0; k < 3; k++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd12, 5'd0, acc);

      random_cycles(1500);

      // Asynchronous reset mid-operation discards queued results.
      @(posedge clk);
      #2;
      mc_valid = 1'b0; hz_rs1 = 5'd1; hz_rs2 = 5'd2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      mq.delete(); starve = 0; prev_stall = 1'b0; mc_pend = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      random_cycles(500);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
